// File: rtl/game_flow_controller.sv
// Game flow sequencer for the VGA maze game: runs the IDLE/READY/PLAY/HIT/
// LEVEL_DONE/GAME_OVER/WIN phases, owns lives, BCD score, level and
// coins-remaining, and drives freeze/respawn/end-of-game indications.
module game_flow_controller #(
   parameter int LIVES_INIT      = 3,
   parameter int COINS_PER_LEVEL = 20,
   parameter int READY_FRAMES    = 60,
   parameter int HIT_FRAMES      = 45,
   parameter int LEVEL_FRAMES    = 90,
   parameter int MAX_LEVEL       = 9
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        start_key,
   input  logic        hit_pulse,
   input  logic        coin_event,
   output logic [2:0]  state,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic [3:0]  level,
   output logic [7:0]  coins_left,
   output logic        freeze,
   output logic        respawn,
   output logic        game_over,
   output logic        win
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READY      = 3'd1,
      PLAY       = 3'd2,
      HIT        = 3'd3,
      LEVEL_DONE = 3'd4,
      GAME_OVER  = 3'd5,
      WIN        = 3'd6
   } state_t;

   localparam logic [15:0] READY_N = 16'(READY_FRAMES);
   localparam logic [15:0] HIT_N   = 16'(HIT_FRAMES);
   localparam logic [15:0] LEVEL_N = 16'(LEVEL_FRAMES);
   localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0]  COINS_LOAD = 8'(COINS_PER_LEVEL);
   localparam logic [3:0]  LAST_LEVEL = 4'(MAX_LEVEL);

   state_t      state_q, state_n;
   logic [1:0]  lives_q, lives_n;
   logic [15:0] score_q, score_n;
   logic [3:0]  level_q, level_n;
   logic [7:0]  coins_q, coins_n;
   logic        respawn_q, respawn_n;
   logic [15:0] frame_cnt_q, frame_cnt_n;
   logic        hit_sem_q, hit_sem_n;
   logic        coin_sem_q, coin_sem_n;
   logic        start_d_q;

   logic        start_edge;
   logic        hit_acc;
   logic        coin_acc;
   logic        timed;
   logic [15:0] frame_target;
   logic        frames_done;

   // Saturating 4-digit BCD increment; 9999 is the ceiling
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Event qualification: only in PLAY, once per frame, and a new frame pulse
   // on the same clk re-opens the window so the event still counts
   always_comb begin
      start_edge = start_key & ~start_d_q;
      hit_acc    = (state_q == PLAY) & hit_pulse & (~hit_sem_q | startOfFrame);
      coin_acc   = (state_q == PLAY) & coin_event & (~coin_sem_q | startOfFrame) & ~hit_acc;
      timed      = (state_q == READY) | (state_q == HIT) | (state_q == LEVEL_DONE);
      case (state_q)
         READY:      frame_target = READY_N;
         HIT:        frame_target = HIT_N;
         LEVEL_DONE: frame_target = LEVEL_N;
         default:    frame_target = 16'd1;
      endcase
      frames_done = timed & startOfFrame & (frame_cnt_q == frame_target - 16'd1);
   end

   // Next-state and next-counter logic for every phase of the game
   always_comb begin
      state_n     = state_q;
      lives_n     = lives_q;
      score_n     = score_q;
      level_n     = level_q;
      coins_n     = coins_q;
      respawn_n   = 1'b0;
      frame_cnt_n = (timed && startOfFrame) ? frame_cnt_q + 16'd1 : frame_cnt_q;
      hit_sem_n   = hit_acc  ? 1'b1 : (startOfFrame ? 1'b0 : hit_sem_q);
      coin_sem_n  = coin_acc ? 1'b1 : (startOfFrame ? 1'b0 : coin_sem_q);

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               lives_n     = LIVES_LOAD;
               score_n     = 16'h0000;
               level_n     = 4'd1;
               coins_n     = COINS_LOAD;
               respawn_n   = 1'b1;
               frame_cnt_n = 16'd0;
               state_n     = READY;
            end
         end
         READY: begin
            if (frames_done) begin
               state_n = PLAY;
            end
         end
         PLAY: begin
            if (hit_acc) begin
               lives_n     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               frame_cnt_n = 16'd0;
               state_n     = HIT;
            end else if (coin_acc) begin
               score_n = bcd_inc(score_q);
               coins_n = (coins_q != 8'd0) ? coins_q - 8'd1 : 8'd0;
               if (coins_q == 8'd1) begin
                  frame_cnt_n = 16'd0;
                  state_n     = LEVEL_DONE;
               end
            end
         end
         HIT: begin
            if (frames_done) begin
               if (lives_q == 2'd0) begin
                  state_n = GAME_OVER;
               end else begin
                  respawn_n   = 1'b1;
                  frame_cnt_n = 16'd0;
                  state_n     = READY;
               end
            end
         end
         LEVEL_DONE: begin
            if (frames_done) begin
               if (level_q == LAST_LEVEL) begin
                  state_n = WIN;
               end else begin
                  level_n     = level_q + 4'd1;
                  coins_n     = COINS_LOAD;
                  respawn_n   = 1'b1;
                  frame_cnt_n = 16'd0;
                  state_n     = READY;
               end
            end
         end
         GAME_OVER, WIN: begin
            if (start_edge) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers; the key delay resets high so a key held
   // through reset is not mistaken for a fresh press
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         lives_q     <= 2'd0;
         score_q     <= 16'h0000;
         level_q     <= 4'd1;
         coins_q     <= 8'd0;
         respawn_q   <= 1'b0;
         frame_cnt_q <= 16'd0;
         hit_sem_q   <= 1'b0;
         coin_sem_q  <= 1'b0;
         start_d_q   <= 1'b1;
      end else begin
         state_q     <= state_n;
         lives_q     <= lives_n;
         score_q     <= score_n;
         level_q     <= level_n;
         coins_q     <= coins_n;
         respawn_q   <= respawn_n;
         frame_cnt_q <= frame_cnt_n;
         hit_sem_q   <= hit_sem_n;
         coin_sem_q  <= coin_sem_n;
         start_d_q   <= start_key;
      end
   end

   assign state      = state_q;
   assign lives      = lives_q;
   assign score      = score_q;
   assign level      = level_q;
   assign coins_left = coins_q;
   assign respawn    = respawn_q;
   assign freeze     = (state_q != PLAY);
   assign game_over  = (state_q == GAME_OVER);
   assign win        = (state_q == WIN);

endmodule

// File: tb/tb_game_flow_controller.sv
// Testbench for game_flow_controller: one instance with default parameters
// and one with a two-coin, two-level game; expectations go through a
// scoreboard queue and are compared once the DUT has clocked.
module tb_game_flow_controller;

   localparam int F_STATE   = 0;
   localparam int F_LIVES   = 1;
   localparam int F_SCORE   = 2;
   localparam int F_LEVEL   = 3;
   localparam int F_COINS   = 4;
   localparam int F_FREEZE  = 5;
   localparam int F_RESPAWN = 6;
   localparam int F_GO      = 7;
   localparam int F_WIN     = 8;

   typedef struct {
      int          dut;
      int          field;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic clk = 1'b0;
   logic resetN = 1'b1;
   logic sof = 1'b0;
   logic key_a = 1'b1, hit_a = 1'b0, coin_a = 1'b0;
   logic key_b = 1'b1, hit_b = 1'b0, coin_b = 1'b0;

   logic [2:0]  state_a, state_b;
   logic [1:0]  lives_a, lives_b;
   logic [15:0] score_a, score_b;
   logic [3:0]  level_a, level_b;
   logic [7:0]  coins_a, coins_b;
   logic        freeze_a, freeze_b, respawn_a, respawn_b;
   logic        go_a, go_b, win_a, win_b;

   game_flow_controller dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(key_a),
      .hit_pulse(hit_a), .coin_event(coin_a), .state(state_a), .lives(lives_a),
      .score(score_a), .level(level_a), .coins_left(coins_a), .freeze(freeze_a),
      .respawn(respawn_a), .game_over(go_a), .win(win_a)
   );

   game_flow_controller #(.COINS_PER_LEVEL(2), .MAX_LEVEL(2)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(key_b),
      .hit_pulse(hit_b), .coin_event(coin_b), .state(state_b), .lives(lives_b),
      .score(score_b), .level(level_b), .coins_left(coins_b), .freeze(freeze_b),
      .respawn(respawn_b), .game_over(go_b), .win(win_b)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   function automatic logic [15:0] getObs(input int d, input int f);
      logic [15:0] v;
      v = 16'hxxxx;
      case (f)
         F_STATE:   v = {13'd0, (d == 0) ? state_a : state_b};
         F_LIVES:   v = {14'd0, (d == 0) ? lives_a : lives_b};
         F_SCORE:   v = (d == 0) ? score_a : score_b;
         F_LEVEL:   v = {12'd0, (d == 0) ? level_a : level_b};
         F_COINS:   v = {8'd0, (d == 0) ? coins_a : coins_b};
         F_FREEZE:  v = {15'd0, (d == 0) ? freeze_a : freeze_b};
         F_RESPAWN: v = {15'd0, (d == 0) ? respawn_a : respawn_b};
         F_GO:      v = {15'd0, (d == 0) ? go_a : go_b};
         F_WIN:     v = {15'd0, (d == 0) ? win_a : win_b};
         default:   v = 16'hxxxx;
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExpect(input int d, input int f, input logic [15:0] v, input string tag);
      exp_t e;
      e.dut   = d;
      e.field = f;
      e.exp   = v;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input int d, input logic s, input logic k, input logic h, input logic c);
      sof    = s;
      key_a  = (d == 0) ? k : 1'b0;
      hit_a  = (d == 0) ? h : 1'b0;
      coin_a = (d == 0) ? c : 1'b0;
      key_b  = (d == 1) ? k : 1'b0;
      hit_b  = (d == 1) ? h : 1'b0;
      coin_b = (d == 1) ? c : 1'b0;
      tick();
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = getObs(e.dut, e.field);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic runFrames(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0);
         applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Leave PLAY-free READY by running out the frame count, then step off the edge
   task automatic readyToPlay(input int d);
      runFrames(d, 59);
      applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(d, F_STATE, 16'd2, "ready_to_play");
      checkOutput();
      applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // ---------------- reset with start key held ----------------
      tick();
      resetN = 1'b0;
      #1;
      pushExpect(0, F_STATE, 16'd0, "rst_state");
      pushExpect(0, F_LIVES, 16'd0, "rst_lives");
      pushExpect(0, F_SCORE, 16'h0000, "rst_score");
      pushExpect(0, F_LEVEL, 16'd1, "rst_level");
      pushExpect(0, F_COINS, 16'd0, "rst_coins");
      pushExpect(0, F_FREEZE, 16'd1, "rst_freeze");
      pushExpect(0, F_RESPAWN, 16'd0, "rst_respawn");
      pushExpect(0, F_GO, 16'd0, "rst_game_over");
      pushExpect(0, F_WIN, 16'd0, "rst_win");
      pushExpect(1, F_STATE, 16'd0, "rst_b_state");
      checkOutput();
      tick();
      tick();
      resetN = 1'b1;
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd0, "held_key_no_start");
      checkOutput();

      // ---------------- start edge ----------------
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd1, "start_state");
      pushExpect(0, F_LIVES, 16'd3, "start_lives");
      pushExpect(0, F_COINS, 16'd20, "start_coins");
      pushExpect(0, F_RESPAWN, 16'd1, "start_respawn");
      pushExpect(0, F_FREEZE, 16'd1, "start_freeze");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushExpect(0, F_RESPAWN, 16'd0, "respawn_one_clk");
      checkOutput();

      // ---------------- READY timing ----------------
      runFrames(0, 59);
      pushExpect(0, F_STATE, 16'd1, "ready_59_frames");
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd2, "ready_60th_frame");
      pushExpect(0, F_FREEZE, 16'd0, "play_freeze");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- coin held across three frames ----------------
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(0, F_SCORE, 16'h0001, "coin_first");
      pushExpect(0, F_COINS, 16'd19, "coin_first_left");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(0, F_SCORE, 16'h0001, "coin_once_per_frame");
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);
      pushExpect(0, F_SCORE, 16'h0002, "coin_with_sof");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushExpect(0, F_SCORE, 16'h0003, "coin3_score");
      pushExpect(0, F_COINS, 16'd17, "coin3_left");
      checkOutput();

      // ---------------- BCD carry and saturation ----------------
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      force dut_a.score_q = 16'h0999;
      #1;
      release dut_a.score_q;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(0, F_SCORE, 16'h1000, "bcd_carry");
      pushExpect(0, F_COINS, 16'd16, "bcd_carry_left");
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      force dut_a.score_q = 16'h9999;
      #1;
      release dut_a.score_q;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(0, F_SCORE, 16'h9999, "bcd_saturate");
      pushExpect(0, F_COINS, 16'd15, "bcd_saturate_left");
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- hit and coin on the same clk ----------------
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1);
      pushExpect(0, F_STATE, 16'd3, "hitcoin_state");
      pushExpect(0, F_LIVES, 16'd2, "hitcoin_lives");
      pushExpect(0, F_COINS, 16'd15, "hitcoin_coin_dropped");
      pushExpect(0, F_SCORE, 16'h9999, "hitcoin_score");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      pushExpect(0, F_LIVES, 16'd2, "hit_ignored_in_hit");
      checkOutput();

      // ---------------- HIT expiry with lives left ----------------
      runFrames(0, 44);
      pushExpect(0, F_STATE, 16'd3, "hit_44_frames");
      checkOutput();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd1, "hit_to_ready");
      pushExpect(0, F_RESPAWN, 16'd1, "hit_respawn");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      readyToPlay(0);

      // ---------------- burn remaining lives ----------------
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      pushExpect(0, F_LIVES, 16'd1, "hit_lives1");
      checkOutput();
      runFrames(0, 45);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      readyToPlay(0);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      pushExpect(0, F_STATE, 16'd3, "last_hit_state");
      pushExpect(0, F_LIVES, 16'd0, "last_hit_lives");
      checkOutput();
      runFrames(0, 44);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd5, "game_over_state");
      pushExpect(0, F_GO, 16'd1, "game_over_flag");
      pushExpect(0, F_RESPAWN, 16'd0, "game_over_no_respawn");
      pushExpect(0, F_FREEZE, 16'd1, "game_over_freeze");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(0, F_STATE, 16'd0, "game_over_to_idle");
      pushExpect(0, F_SCORE, 16'h9999, "idle_keeps_score");
      checkOutput();

      // ---------------- async reset during HIT ----------------
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(0, F_LIVES, 16'd3, "restart_lives");
      pushExpect(0, F_SCORE, 16'h0000, "restart_score");
      checkOutput();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      readyToPlay(0);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      pushExpect(0, F_STATE, 16'd3, "pre_reset_hit");
      checkOutput();
      #2;
      resetN = 1'b0;
      #1;
      pushExpect(0, F_STATE, 16'd0, "async_rst_state");
      pushExpect(0, F_LIVES, 16'd0, "async_rst_lives");
      pushExpect(0, F_FREEZE, 16'd1, "async_rst_freeze");
      checkOutput();
      tick();
      resetN = 1'b1;

      // ---------------- two-level game on dut_b ----------------
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(1, F_STATE, 16'd1, "b_start");
      pushExpect(1, F_COINS, 16'd2, "b_start_coins");
      checkOutput();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      readyToPlay(1);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(1, F_COINS, 16'd1, "b_coin_once");
      checkOutput();
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
      pushExpect(1, F_STATE, 16'd4, "b_level_done");
      pushExpect(1, F_COINS, 16'd0, "b_level_done_coins");
      pushExpect(1, F_SCORE, 16'h0002, "b_level_done_score");
      checkOutput();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      runFrames(1, 89);
      pushExpect(1, F_STATE, 16'd4, "b_level_89_frames");
      checkOutput();
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(1, F_STATE, 16'd1, "b_level2_ready");
      pushExpect(1, F_LEVEL, 16'd2, "b_level2");
      pushExpect(1, F_COINS, 16'd2, "b_level2_coins");
      pushExpect(1, F_RESPAWN, 16'd1, "b_level2_respawn");
      pushExpect(1, F_LIVES, 16'd3, "b_level2_lives");
      checkOutput();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      readyToPlay(1);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1);
      pushExpect(1, F_STATE, 16'd4, "b_sof_coin_same_clk");
      pushExpect(1, F_SCORE, 16'h0004, "b_score4");
      checkOutput();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      runFrames(1, 89);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
      pushExpect(1, F_STATE, 16'd6, "b_win_state");
      pushExpect(1, F_WIN, 16'd1, "b_win_flag");
      pushExpect(1, F_LEVEL, 16'd2, "b_win_level");
      pushExpect(1, F_FREEZE, 16'd1, "b_win_freeze");
      checkOutput();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExpect(1, F_STATE, 16'd0, "b_win_to_idle");
      pushExpect(1, F_LEVEL, 16'd2, "b_idle_keeps_level");
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
